// File: rtl/datapath_pkg.sv
// Shared widths and opcode encodings for the 16-bit teaching processor datapath.
package datapath_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1111;

endpackage

// File: rtl/datapath_core_alu.sv
// Combinational ALU; opcodes without an ALU meaning produce zero.
module alu_unit
    import datapath_pkg::*;
#(
    parameter int DATA_W_P = DATA_W
) (
    input  logic [3:0]          opcode,
    input  logic [DATA_W_P-1:0] op_a,
    input  logic [DATA_W_P-1:0] op_b,
    output logic [DATA_W_P-1:0] result,
    output logic                zero
);

    // Operation select; carry and borrow fall off the top of the datapath.
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_PASS: result = op_a;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/datapath_core_reg_bank.sv
// Register bank: 2^ADDR_W general-purpose registers, two combinational read
// ports, one synchronous write port sharing its address with read port A.
module reg_bank
    import datapath_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W_P-1:0] addr_a,
    input  logic [ADDR_W_P-1:0] addr_b,
    input  logic                wr_en,
    input  logic [DATA_W_P-1:0] wr_data,
    output logic [DATA_W_P-1:0] rd_data_a,
    output logic [DATA_W_P-1:0] rd_data_b
);

    localparam int NUM_REGS = 2 ** ADDR_W_P;

    logic [DATA_W_P-1:0] regs_q [NUM_REGS];
    logic [DATA_W_P-1:0] regs_d [NUM_REGS];

    // Next-state of the bank: only the addressed register changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[addr_a] = wr_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Bank storage; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads are deliberately unbypassed: a write shows up only after the edge.
    assign rd_data_a = regs_q[addr_a];
    assign rd_data_b = regs_q[addr_b];

endmodule

// File: rtl/datapath_core.sv
// Register-file-plus-ALU datapath; the ALU operands are the two read ports.
module datapath_core
    import datapath_pkg::*;
#(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int ADDR_W = datapath_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero
);

    reg_bank #(
        .DATA_W_P (DATA_W),
        .ADDR_W_P (ADDR_W)
    ) u_reg_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_a    (address_a),
        .addr_b    (address_b),
        .wr_en     (write_enable),
        .wr_data   (write_data),
        .rd_data_a (data_a),
        .rd_data_b (data_b)
    );

    alu_unit #(
        .DATA_W_P (DATA_W)
    ) u_alu_unit (
        .opcode (opcode),
        .op_a   (data_a),
        .op_b   (data_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_datapath_core;

    logic        clk;
    logic        rst_n;
    logic [2:0]  address_a;
    logic [2:0]  address_b;
    logic        write_enable;
    logic [15:0] write_data;
    logic [3:0]  opcode;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [15:0] alu_result;
    logic        alu_zero;

    int tests_run;
    int tests_failed;
    int unsigned mdl [8];

    datapath_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address_a    (address_a),
        .address_b    (address_b),
        .write_enable (write_enable),
        .write_data   (write_data),
        .opcode       (opcode),
        .data_a       (data_a),
        .data_b       (data_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned ref_alu(input int unsigned op, input int unsigned a, input int unsigned b);
        int unsigned r;
        case (op)
            2:       r = (a + b) % 65536;
            3:       r = (a + 65536 - b) % 65536;
            4:       r = a & b;
            5:       r = a | b;
            6:       r = a ^ b;
            7:       r = a;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic write_reg(input logic [2:0] ad, input logic [15:0] d);
        @(negedge clk);
        address_a    = ad;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        mdl[ad]      = d;
    endtask

    task automatic test_reset();
        write_reg(3'd3, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = 0;
        address_a = 3'd3;
        address_b = 3'd7;
        opcode    = 4'b0010;
        #1;
        tests_run++;
        if (data_a !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_r3: got %h expected 0000", data_a);
        end
        tests_run++;
        if (data_b !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_r7: got %h expected 0000", data_b);
        end
        tests_run++;
        if (alu_zero !== 1'b1 || alu_result !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_alu: got result %h zero %b expected 0000 1", alu_result, alu_zero);
        end
    endtask

    task automatic test_write_read();
        write_reg(3'd1, 16'h0005);
        write_reg(3'd2, 16'h0003);
        address_a = 3'd1;
        address_b = 3'd2;
        opcode    = 4'b0010;
        #1;
        tests_run++;
        if (alu_result !== 16'h0008 || alu_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_basic: got %h zero %b expected 0008 0", alu_result, alu_zero);
        end
        opcode = 4'b0011;
        #1;
        tests_run++;
        if (alu_result !== 16'h0002) begin
            tests_failed++;
            $display("FAIL sub_basic: got %h expected 0002", alu_result);
        end
    endtask

    task automatic test_zero_wrap();
        logic [15:0] ra [3];
        logic [15:0] rb [3];
        logic [3:0]  op [3];
        logic [15:0] exp_r [3];
        ra = '{16'h0005, 16'h0003, 16'hFFFF};
        rb = '{16'h0005, 16'h0005, 16'h0001};
        op = '{4'b0011, 4'b0011, 4'b0010};
        exp_r = '{16'h0000, 16'hFFFE, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            write_reg(3'd1, ra[i]);
            write_reg(3'd2, rb[i]);
            address_a = 3'd1;
            address_b = 3'd2;
            opcode    = op[i];
            #1;
            tests_run++;
            if (alu_result !== exp_r[i] || alu_zero !== (exp_r[i] == 16'h0000)) begin
                tests_failed++;
                $display("FAIL zero_wrap_%0d: got %h zero %b expected %h", i, alu_result, alu_zero, exp_r[i]);
            end
        end
    endtask

    task automatic test_no_bypass();
        write_reg(3'd4, 16'h0011);
        @(negedge clk);
        address_a    = 3'd4;
        write_data   = 16'h00AA;
        write_enable = 1'b1;
        #1;
        tests_run++;
        if (data_a !== 16'h0011) begin
            tests_failed++;
            $display("FAIL no_bypass_before: got %h expected 0011", data_a);
        end
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        mdl[4] = 32'h00AA;
        tests_run++;
        if (data_a !== 16'h00AA) begin
            tests_failed++;
            $display("FAIL no_bypass_after: got %h expected 00aa", data_a);
        end
    endtask

    task automatic test_logic_unimpl();
        logic [3:0]  op [5];
        logic [15:0] exp_r [5];
        op    = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1111};
        exp_r = '{16'h00F0, 16'h0FF0, 16'h0F00, 16'h00F0, 16'h0000};
        write_reg(3'd1, 16'h00F0);
        write_reg(3'd2, 16'h0FF0);
        address_a = 3'd1;
        address_b = 3'd2;
        for (int i = 0; i < 5; i++) begin
            opcode = op[i];
            #1;
            tests_run++;
            if (alu_result !== exp_r[i] || alu_zero !== (exp_r[i] == 16'h0000)) begin
                tests_failed++;
                $display("FAIL logic_op_%h: got %h zero %b expected %h", op[i], alu_result, alu_zero, exp_r[i]);
            end
        end
    endtask

    task automatic test_reset_vs_write();
        write_reg(3'd5, 16'h7777);
        @(negedge clk);
        rst_n        = 1'b0;
        address_a    = 3'd5;
        write_data   = 16'h1234;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        write_enable = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 0;
        #1;
        tests_run++;
        if (data_a !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_vs_write: got %h expected 0000", data_a);
        end
    endtask

    task automatic test_random();
        int unsigned ea;
        int unsigned eb;
        int unsigned er;
        logic        do_rst;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            do_rst       = ($urandom_range(0, 19) == 0);
            rst_n        = !do_rst;
            address_a    = 3'($urandom_range(0, 7));
            address_b    = ($urandom_range(0, 3) == 0) ? address_a : 3'($urandom_range(0, 7));
            write_enable = 1'($urandom_range(0, 1));
            write_data   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            opcode       = 4'($urandom_range(0, 15));
            #1;
            ea = mdl[address_a];
            eb = mdl[address_b];
            er = ref_alu(opcode, ea, eb);
            tests_run++;
            if (data_a !== 16'(ea) || data_b !== 16'(eb) || alu_result !== 16'(er) || alu_zero !== (er == 0)) begin
                tests_failed++;
                $display("FAIL random_%0d: got a=%h b=%h r=%h z=%b expected a=%h b=%h r=%h z=%b",
                         n, data_a, data_b, alu_result, alu_zero, 16'(ea), 16'(eb), 16'(er), (er == 0));
            end
            @(posedge clk);
            if (do_rst) begin
                for (int i = 0; i < 8; i++) mdl[i] = 0;
            end else if (write_enable) begin
                mdl[address_a] = write_data;
            end else begin
                mdl[0] = mdl[0];
            end
        end
        #1;
        rst_n        = 1'b1;
        write_enable = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        address_a    = 3'd0;
        address_b    = 3'd0;
        write_enable = 1'b0;
        write_data   = 16'h0000;
        opcode       = 4'b0000;
        for (int i = 0; i < 8; i++) mdl[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_zero_wrap();
        test_no_bypass();
        test_logic_unimpl();
        test_reset_vs_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
